// File: rtl/reset_sequencer_pkg.sv
// Shared types and default timing constants for the reset sequencer and the power-on reset generator.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_NUM_STAGES  = 3;
    localparam int unsigned DEF_LOCK_FILTER = 1024;
    localparam int unsigned DEF_STAGE_DELAY = 256;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned DEF_CNT_W       = 23;

    // Stage index width; a single-stage sequencer still needs one bit.
    function automatic int unsigned stage_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high clear, for asynchronous status inputs.
module sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Filters clock-manager lock and releases domain resets one at a time, re-asserting all on lock loss or soft request.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
    parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER,
    parameter int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned STAGE_W = stage_w(NUM_STAGES);

    localparam logic [CNT_W-1:0]   FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]   DELAY_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(NUM_STAGES - 1);

    seq_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [STAGE_W-1:0] stage;
    logic               locked_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .clr (reset),
        .d   (locked),
        .q   (locked_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            stage   <= '0;
            rst_out <= '1;
            done    <= 1'b0;
            busy    <= 1'b1;
        end else if (state != WAIT_LOCK && !locked_s) begin
            // Lock loss outranks soft requests and any stage release due this edge.
            state   <= WAIT_LOCK;
            cnt     <= '0;
            stage   <= '0;
            rst_out <= '1;
            done    <= 1'b0;
            busy    <= 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!locked_s) begin
                        cnt <= '0;
                    end else if (cnt == FILTER_LAST) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        stage <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == DELAY_LAST) begin
                        rst_out[stage] <= 1'b0;
                        cnt            <= '0;
                        if (stage == LAST_STAGE) begin
                            state <= RUN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            stage <= stage + STAGE_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (soft_reset_req) begin
                        state   <= HOLD;
                        rst_out <= '1;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up vector table plus hand-written lock, soft and async-reset sequences.
module tb_reset_sequencer;

    localparam int unsigned NS = 3;
    localparam int unsigned LF = 4;
    localparam int unsigned SD = 3;
    localparam int unsigned HC = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          locked;
    logic          soft_reset_req;
    logic [NS-1:0] rst_out;
    logic          done;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic          r;
        logic          l;
        logic          s;
        logic [NS-1:0] e_rst;
        logic          e_done;
        logic          e_busy;
    } vec_t;

    reset_sequencer #(
        .NUM_STAGES  (NS),
        .LOCK_FILTER (LF),
        .STAGE_DELAY (SD),
        .HOLD_CYCLES (HC),
        .CNT_W       (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .locked         (locked),
        .soft_reset_req (soft_reset_req),
        .rst_out        (rst_out),
        .done           (done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NS-1:0] e_rst, input logic e_done, input logic e_busy);
        n_cmp++;
        if (rst_out !== e_rst || done !== e_done || busy !== e_busy) begin
            n_fail++;
            $display("FAIL %s t=%0t: got rst_out=%b done=%b busy=%b, want rst_out=%b done=%b busy=%b",
                     name, $time, rst_out, done, busy, e_rst, e_done, e_busy);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the rising edge.
    task automatic tick(input logic r, input logic l, input logic s);
        @(negedge clk);
        reset          = r;
        locked         = l;
        soft_reset_req = s;
        @(posedge clk);
        #1;
    endtask

    // Expected output at edge e of a release run whose bit 0 falls at edge first_fall.
    task automatic expect_edge(input string name, input int e, input int first_fall);
        if (e < first_fall)
            chk(name, 3'b111, 1'b0, 1'b1);
        else if (e < first_fall + int'(SD))
            chk(name, 3'b110, 1'b0, 1'b1);
        else if (e < first_fall + 2 * int'(SD))
            chk(name, 3'b100, 1'b0, 1'b1);
        else
            chk(name, 3'b000, 1'b1, 1'b0);
    endtask

    // Runs edges 1..last_edge with locked high; soft_reset_req pulses at edge soft_at (0 = never).
    task automatic run_seq(input string name, input int first_fall, input int last_edge, input int soft_at);
        for (int e = 1; e <= last_edge; e++) begin
            tick(1'b0, 1'b1, (e == soft_at) ? 1'b1 : 1'b0);
            expect_edge(name, e, first_fall);
        end
    endtask

    vec_t vecs[$];

    initial begin
        reset          = 1'b1;
        locked         = 1'b1;
        soft_reset_req = 1'b0;

        // Power-up: 5 reset cycles, then edges 1..16 with bit falls at 9, 12, 15.
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1});
        for (int e = 1; e <= 8; e++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1});
        for (int e = 9; e <= 11; e++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1});
        for (int e = 12; e <= 14; e++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1});
        for (int e = 15; e <= 16; e++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            tick(vecs[i].r, vecs[i].l, vecs[i].s);
            chk($sformatf("powerup[%0d]", i), vecs[i].e_rst, vecs[i].e_done, vecs[i].e_busy);
        end

        // Lock loss in RUN: all reset 3 edges after locked drops.
        tick(1'b0, 1'b0, 1'b0); chk("lockloss_e1", 3'b000, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0); chk("lockloss_e2", 3'b000, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0); chk("lockloss_e3", 3'b111, 1'b0, 1'b1);
        run_seq("relock", 9, 16, 0);

        // Soft reset in RUN, then a pulse during RELEASE that must be ignored.
        tick(1'b0, 1'b1, 1'b1); chk("soft_enter", 3'b111, 1'b0, 1'b1);
        run_seq("soft_hold", 12, 18, 13);

        // Soft request while in RUN gets no special treatment once cleared: still in RUN.
        tick(1'b0, 1'b1, 1'b0); chk("run_steady", 3'b000, 1'b1, 1'b0);

        // Lock glitch while filtering at count 2.
        tick(1'b1, 1'b1, 1'b0); chk("glitch_rst", 3'b111, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0); chk("glitch_e1", 3'b111, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0); chk("glitch_e2", 3'b111, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0); chk("glitch_e3", 3'b111, 1'b0, 1'b1);
        run_seq("glitch_rel", 9, 16, 0);

        // Async reset mid-RELEASE, after bit 0 released.
        tick(1'b1, 1'b1, 1'b0);
        run_seq("pre_async", 9, 10, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_imm", 3'b111, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0); chk("async_hold", 3'b111, 1'b0, 1'b1);
        run_seq("post_async", 9, 16, 0);

        // Lock loss landing on the edge where bit 1 is due.
        tick(1'b1, 1'b1, 1'b0);
        run_seq("simul_pre", 9, 9, 0);
        tick(1'b0, 1'b0, 1'b0); chk("simul_e10", 3'b110, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0); chk("simul_e11", 3'b110, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0); chk("simul_e12", 3'b111, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0); chk("simul_e13", 3'b111, 1'b0, 1'b1);
        run_seq("simul_relock", 9, 16, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
